// File: rtl/active_list.sv
// active_list: in-order retirement buffer for the register-renaming pipeline.
// Completed entries retire in program order; a flush walks tail back to head, one entry per cycle.
module active_list #(
    parameter int FREE_LIST_WIDTH = 3,
    parameter int VREG_WIDTH      = 5,
    parameter int PREG_WIDTH      = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       global_flush,
    input  logic                       alloc_valid,
    input  logic [VREG_WIDTH-1:0]      alloc_vreg,
    input  logic [PREG_WIDTH-1:0]      alloc_new_preg,
    input  logic [PREG_WIDTH-1:0]      alloc_old_preg,
    output logic                       alloc_ready,
    output logic [FREE_LIST_WIDTH-1:0] alloc_index,
    input  logic                       done_valid,
    input  logic [FREE_LIST_WIDTH-1:0] done_index,
    output logic                       commit_valid,
    output logic [VREG_WIDTH-1:0]      commit_vreg,
    output logic [PREG_WIDTH-1:0]      commit_new_preg,
    output logic [PREG_WIDTH-1:0]      commit_old_preg,
    output logic                       rollback_valid,
    output logic [VREG_WIDTH-1:0]      rollback_vreg,
    output logic [PREG_WIDTH-1:0]      rollback_old_preg,
    output logic [PREG_WIDTH-1:0]      rollback_new_preg,
    output logic [FREE_LIST_WIDTH:0]   count,
    output logic                       rolling_back
);
    localparam int DEPTH = 2 ** FREE_LIST_WIDTH;
    localparam logic [FREE_LIST_WIDTH:0]   FULL_CNT = (FREE_LIST_WIDTH + 1)'(DEPTH);
    localparam logic [FREE_LIST_WIDTH:0]   CNT_ONE  = (FREE_LIST_WIDTH + 1)'(1);
    localparam logic [FREE_LIST_WIDTH-1:0] PTR_ONE  = (FREE_LIST_WIDTH)'(1);

    typedef enum logic {RUN = 1'b0, ROLLBACK = 1'b1} state_t;

    state_t state;
    state_t state_nxt;

    logic [DEPTH-1:0]           ent_valid;
    logic [DEPTH-1:0]           ent_done;
    logic [VREG_WIDTH-1:0]      vreg_mem [DEPTH];
    logic [PREG_WIDTH-1:0]      new_mem  [DEPTH];
    logic [PREG_WIDTH-1:0]      old_mem  [DEPTH];
    logic [FREE_LIST_WIDTH-1:0] head;
    logic [FREE_LIST_WIDTH-1:0] tail;
    logic [FREE_LIST_WIDTH-1:0] tail_prev;
    logic                       run_ok;
    logic                       do_alloc;
    logic                       do_done;
    logic                       do_commit;
    logic                       do_rb;

    // A flush cycle in RUN freezes alloc, completion and commit alike.
    assign run_ok    = (state == RUN) && !global_flush;
    assign do_alloc  = run_ok && alloc_valid && alloc_ready;
    assign do_done   = run_ok && done_valid && ent_valid[done_index];
    assign do_commit = run_ok && ent_valid[head] && ent_done[head];
    assign do_rb     = (state == ROLLBACK);
    assign tail_prev = tail - PTR_ONE;

    assign alloc_index = tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (global_flush && (count != '0)) state_nxt = ROLLBACK;
            ROLLBACK: if (count == CNT_ONE) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        alloc_ready  = (state == RUN) && (count < FULL_CNT);
        rolling_back = (state == ROLLBACK);
    end

    // Pointer and status bookkeeping; commit reads the done bit as it stood before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (do_done) begin
                ent_done[done_index] <= 1'b1;
            end
            if (do_alloc) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + PTR_ONE;
            end
            if (do_commit) begin
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
                head            <= head + PTR_ONE;
            end
            if (do_rb) begin
                ent_valid[tail_prev] <= 1'b0;
                ent_done[tail_prev]  <= 1'b0;
                tail                 <= tail_prev;
            end
            if (do_rb || (do_commit && !do_alloc)) begin
                count <= count - CNT_ONE;
            end else if (do_alloc && !do_commit) begin
                count <= count + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            vreg_mem[tail] <= alloc_vreg;
            new_mem[tail]  <= alloc_new_preg;
            old_mem[tail]  <= alloc_old_preg;
        end
    end

    // Retire stage boundary: registered commit and rollback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid      <= 1'b0;
            commit_vreg       <= '0;
            commit_new_preg   <= '0;
            commit_old_preg   <= '0;
            rollback_valid    <= 1'b0;
            rollback_vreg     <= '0;
            rollback_old_preg <= '0;
            rollback_new_preg <= '0;
        end else begin
            commit_valid   <= do_commit;
            rollback_valid <= do_rb;
            if (do_commit) begin
                commit_vreg     <= vreg_mem[head];
                commit_new_preg <= new_mem[head];
                commit_old_preg <= old_mem[head];
            end
            if (do_rb) begin
                rollback_vreg     <= vreg_mem[tail_prev];
                rollback_old_preg <= old_mem[tail_prev];
                rollback_new_preg <= new_mem[tail_prev];
            end
        end
    end

endmodule

// File: doc/active_list.md
Name: active_list

Overview:
- In-order retirement buffer for the register-renaming pipeline.
- The rename stage allocates one entry per register-writing instruction. The entry index travels down the pipeline as active_list_index and returns from the MEM→WB register as a completion.
- Completed entries retire strictly in program order. Each retirement emits the old physical register to the free list.
- On global_flush, the block walks back from tail to head, one entry per cycle, so the rename map is restored and the new physical registers are released.

Parameters:
- FREE_LIST_WIDTH, 3, index width; DEPTH = 2**FREE_LIST_WIDTH (8 entries)
- VREG_WIDTH, 5, architectural register address width
- PREG_WIDTH, 6, physical register address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- global_flush  in  1  squash all uncommitted entries
- alloc_valid  in  1  rename requests an entry
- alloc_vreg  in  VREG_WIDTH  architectural destination
- alloc_new_preg  in  PREG_WIDTH  newly mapped physical register
- alloc_old_preg  in  PREG_WIDTH  previous mapping of alloc_vreg
- alloc_ready  out  1  entry available; combinational = (state==RUN && count<DEPTH)
- alloc_index  out  FREE_LIST_WIDTH  current tail; the index assigned if accepted
- done_valid  in  1  completion from the writeback side
- done_index  in  FREE_LIST_WIDTH  completed entry
- commit_valid  out  1  registered; one retirement this cycle
- commit_vreg  out  VREG_WIDTH  retired architectural register
- commit_new_preg  out  PREG_WIDTH  now-committed mapping
- commit_old_preg  out  PREG_WIDTH  physical register to free
- rollback_valid  out  1  registered; one squashed entry this cycle
- rollback_vreg  out  VREG_WIDTH  map entry to restore
- rollback_old_preg  out  PREG_WIDTH  value to restore into map
- rollback_new_preg  out  PREG_WIDTH  physical register to free
- count  out  FREE_LIST_WIDTH+1  occupied entries
- rolling_back  out  1  state==ROLLBACK

Behaviour:
- Storage per entry:
  - valid and done bits
  - vreg, new_preg, old_preg fields
- Pointers:
  - head and tail are FREE_LIST_WIDTH bits and wrap modulo DEPTH.
  - count distinguishes full from empty.
- Reset (async):
  - head=tail=0, count=0, all valid/done bits=0, state=RUN.
  - All registered outputs = 0.
  - alloc_ready=1, alloc_index=0.
- States are RUN and ROLLBACK.
- RUN, no global_flush, each clock edge:
  - Alloc:
    - If alloc_valid && alloc_ready, write the fields at tail, set valid=1, done=0, tail++.
    - When full, the request is ignored, even if a commit occurs in the same cycle.
  - Complete:
    - If done_valid && valid[done_index], set done[done_index]=1.
    - Completion to an invalid entry is ignored.
  - Commit:
    - If valid[head] && done[head] at the start of the cycle, register commit_valid=1 with the head fields, clear valid/done[head], head++.
    - Otherwise commit_valid=0.
    - Maximum one commit per cycle.
  - Latency: done_index sampled at edge N → commit_valid high after edge N+1, at the earliest.
  - count: +1 on alloc, −1 on commit; both in the same cycle leaves it unchanged.
- global_flush sampled in RUN:
  - Alloc, complete and commit are all suppressed in that cycle, and commit_valid <= 0.
  - If count>0, go to ROLLBACK; otherwise remain in RUN.
- ROLLBACK, each edge:
  - Register rollback_valid=1 with the fields of entry tail−1.
  - Clear that entry's valid/done bits, tail--, count--.
  - When count reaches 1 → 0, return to RUN on that edge.
  - alloc_ready=0 throughout; done_valid, commit and global_flush are ignored.
  - Result: rollback order is youngest→oldest, exactly count cycles.
- rollback_valid=0 in every cycle not emitting a rollback.
- After rollback, head==tail at the pre-flush head. Pointers are not reset.
- Simultaneous completion of head and commit evaluation: the commit uses the done bit before the edge, so it occurs one cycle later.

Test Plan:
1. Reset check:
   - Stimulus: assert rst_n=0 mid-operation with count=4.
   - Required response: immediately all outputs 0, count=0, alloc_ready=1, alloc_index=0.
   - After release, the first alloc gets index 0.
2. In-order commit:
   - Stimulus: alloc (vreg,new,old) = (1,33,1), (2,34,2), (3,35,3) at indices 0,1,2. Complete index 1, then index 0.
   - Required response: no commit after index 1 completes. Then commit (1,33,1) followed next cycle by (2,34,2). Index 2 stays pending, count=1.
3. Full and wrap:
   - Stimulus: alloc 8 entries, then a 9th alloc.
   - Required response: count=8, alloc_ready=0, 9th alloc ignored.
   - Stimulus: complete index 0.
   - Required response: commit, count=7, alloc_ready=1, next alloc gets index 0 (wrap). Continue until tail wraps 7→0 twice without loss.
4. Flush rollback:
   - Stimulus: with head=5 and entries 5,6,7 valid (7 done), pulse global_flush.
   - Required response: no commit of 7. Rollback emitted for 7, 6, 5 on three consecutive cycles, alloc_ready=0 during rollback.
   - Afterwards: state RUN, head=tail=5, count=0, next alloc_index=5.
5. Ignored inputs:
   - Stimulus: done_index pointing to an empty slot; done_valid in the flush cycle; global_flush during ROLLBACK.
   - Required response: done bits unchanged, no extra rollbacks, rollback count equals the pre-flush count.
6. Empty flush:
   - Stimulus: global_flush with count=0.
   - Required response: stays in RUN, rollback_valid never asserts, alloc accepted on the next cycle.
